bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 115 +++++++++++
 tb/tb_bit_serializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Serial transmit stage: accepts a number and its significant length on md_start,
// then shifts that many bits out MSB-first on a 1-bit valid/ready stream.
// All outputs come straight from flops.
module bit_serializer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              md_start,
    input  logic [DATA_W-1:0] num_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              bit_ready,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              bit_last,
    output logic              busy,
    output logic              md_end
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              bit_valid_q, bit_valid_d;
    logic              bit_last_q, bit_last_d;
    logic              busy_q, busy_d;
    logic              md_end_q, md_end_d;

    logic [31:0]       len_ext;
    logic [CntW-1:0]   len_eff;
    logic              xfer;

    // Clamp the requested length to the data width.
    always_comb begin
        len_ext = 32'(len_in);
        len_eff = (len_ext > DATA_W) ? CntW'(DATA_W) : CntW'(len_ext);
    end

    assign xfer = bit_valid_q & bit_ready;

    // Next-state logic; the field is left-aligned on accept so the MSB is always the next bit.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        bit_valid_d = 1'b0;
        bit_last_d  = 1'b0;
        busy_d      = 1'b0;
        md_end_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (md_start) begin
                    // Shift by DATA_W for a zero-length job clears the register.
                    shreg_d = num_in << (CntW'(DATA_W) - len_eff);
                    cnt_d   = len_eff;
                    state_d = (len_eff == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (xfer) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        bit_valid_d = (state_d == StShift);
        bit_last_d  = (state_d == StShift) && (cnt_d == CntW'(1));
        busy_d      = (state_d != StIdle);
        md_end_d    = (state_d == StDone);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            md_end_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bit_valid_q <= bit_valid_d;
            bit_last_q  <= bit_last_d;
            busy_q      <= busy_d;
            md_end_q    <= md_end_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = shreg_q[DATA_W-1];
    assign bit_last  = bit_last_q;
    assign busy      = busy_q;
    assign md_end    = md_end_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus random jobs checked
// against a queue-based reference of the expected bit stream.
module tb_bit_serializer;

    logic        clk;
    logic        rstn;
    logic        md_start;
    logic [63:0] num_in;
    logic [7:0]  len_in;
    logic        bit_ready;
    logic        bit_valid;
    logic        bit_out;
    logic        bit_last;
    logic        busy;
    logic        md_end;

    int tests_run;
    int tests_failed;

    // Observations from the last job
    logic obs_bits[$];
    logic exp_bits[$];
    int   last_cnt, last_idx, md_end_cycle, busy_bad, stab_bad, valid_cycles, last_xfer_cycle;
    logic post_md_end, post_busy, post_valid;
    bit   pat[0:255];

    bit_serializer #(.DATA_W(64), .LEN_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .md_start  (md_start),
        .num_in    (num_in),
        .len_in    (len_in),
        .bit_ready (bit_ready),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .busy      (busy),
        .md_end    (md_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the first min(len, 64) bits of num, highest first.
    task automatic build_exp(input logic [63:0] num, input logic [7:0] len);
        int leff;
        leff = (int'(len) > 64) ? 64 : int'(len);
        exp_bits.delete();
        for (int i = leff - 1; i >= 0; i--) exp_bits.push_back(num[i]);
    endtask

    function automatic int bit_diff();
        int d;
        d = (obs_bits.size() > exp_bits.size()) ? obs_bits.size() - exp_bits.size()
                                                : exp_bits.size() - obs_bits.size();
        for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++)
            if (obs_bits[i] !== exp_bits[i]) d++;
        return d;
    endfunction

    // Drives one job from IDLE and records what the stream does; no checking here.
    task automatic run_job(input logic [63:0] num, input logic [7:0] len, input int pct,
                           input bit use_pat, input int poke);
        logic pv, pr, pb, pl;
        bit   rdy;
        obs_bits.delete();
        last_cnt = 0; last_idx = -1; md_end_cycle = -1; busy_bad = 0; stab_bad = 0;
        valid_cycles = 0; last_xfer_cycle = 0;
        md_start = 1'b1; num_in = num; len_in = len; bit_ready = 1'b0;
        tick();
        md_start = 1'b0;
        num_in = {$urandom, $urandom};
        len_in = 8'($urandom);
        pv = 1'b0; pr = 1'b0; pb = 1'b0; pl = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            md_start = (poke != 0) && (c == poke);
            if (md_start) begin
                num_in = ~num;
                len_in = 8'd5;
            end
            if (pv && !pr && (bit_valid !== 1'b1 || bit_out !== pb || bit_last !== pl))
                stab_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (bit_valid === 1'b1) valid_cycles++;
            if (md_end === 1'b1) begin
                md_end_cycle = c;
                break;
            end
            rdy = use_pat ? pat[c] : ($urandom_range(0, 99) < pct);
            bit_ready = rdy;
            if (bit_valid === 1'b1 && rdy) begin
                obs_bits.push_back(bit_out);
                if (bit_last === 1'b1) begin
                    last_cnt++;
                    last_idx = obs_bits.size() - 1;
                end
                last_xfer_cycle = c;
            end
            pv = bit_valid; pr = rdy; pb = bit_out; pl = bit_last;
            tick();
        end
        md_start = 1'b0;
        bit_ready = 1'b0;
        tick();
        post_md_end = md_end; post_busy = busy; post_valid = bit_valid;
    endtask

    task automatic test_reset();
        rstn = 1'b0; md_start = 1'b0; num_in = '0; len_in = '0; bit_ready = 1'b0;
        tick(); tick();
        tests_run++;
        if ({bit_valid, bit_out, bit_last, busy, md_end} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {bit_valid, bit_out, bit_last, busy, md_end});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        build_exp(64'h9, 8'd4);
        run_job(64'h9, 8'd4, 100, 1'b0, 0);
        tests_run++;
        if (bit_diff() != 0) begin
            tests_failed++;
            $display("FAIL basic_bits: got %0d bits, %0d diffs, want 1001", obs_bits.size(),
                     bit_diff());
        end
        tests_run++;
        if (md_end_cycle !== 5 || busy_bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_timing: md_end cycle %0d busy_bad %0d, want 5 and 0",
                     md_end_cycle, busy_bad);
        end
        tests_run++;
        if (last_cnt !== 1 || last_idx !== 3) begin
            tests_failed++;
            $display("FAIL basic_last: count %0d idx %0d, want 1 and 3", last_cnt, last_idx);
        end
        tests_run++;
        if ({post_md_end, post_busy, post_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL basic_idle_after: md_end/busy/valid %b, want 000",
                     {post_md_end, post_busy, post_valid});
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 256; i++) pat[i] = 1'b1;
        pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
        build_exp(64'h5, 8'd3);
        run_job(64'h5, 8'd3, 0, 1'b1, 0);
        tests_run++;
        if (bit_diff() != 0 || obs_bits.size() != 3) begin
            tests_failed++;
            $display("FAIL bp_bits: got %0d transfers, %0d diffs, want 3 transfers of 101",
                     obs_bits.size(), bit_diff());
        end
        tests_run++;
        if (stab_bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stab_bad);
        end
        tests_run++;
        if (md_end_cycle !== 7) begin
            tests_failed++;
            $display("FAIL bp_md_end: cycle %0d, want 7", md_end_cycle);
        end
    endtask

    task automatic test_zero_len();
        run_job(64'hFF, 8'd0, 100, 1'b0, 0);
        tests_run++;
        if (valid_cycles !== 0 || md_end_cycle !== 1) begin
            tests_failed++;
            $display("FAIL zero_len: valid cycles %0d md_end cycle %0d, want 0 and 1",
                     valid_cycles, md_end_cycle);
        end
        tests_run++;
        if ({post_md_end, post_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_len_idle: md_end/busy %b, want 00", {post_md_end, post_busy});
        end
    endtask

    task automatic test_clamp();
        build_exp(64'h8000_0000_0000_0001, 8'd200);
        run_job(64'h8000_0000_0000_0001, 8'd200, 100, 1'b0, 0);
        tests_run++;
        if (bit_diff() != 0 || obs_bits.size() != 64) begin
            tests_failed++;
            $display("FAIL clamp_bits: got %0d bits, %0d diffs, want 64 bits 1,0*62,1",
                     obs_bits.size(), bit_diff());
        end
        tests_run++;
        if (md_end_cycle !== 65 || last_cnt !== 1 || last_idx !== 63) begin
            tests_failed++;
            $display("FAIL clamp_timing: md_end %0d last cnt %0d idx %0d, want 65 1 63",
                     md_end_cycle, last_cnt, last_idx);
        end
    endtask

    task automatic test_ignore_and_abort();
        int bad;
        build_exp(64'hA5, 8'd8);
        run_job(64'hA5, 8'd8, 100, 1'b0, 3);
        tests_run++;
        if (bit_diff() != 0 || md_end_cycle !== 9) begin
            tests_failed++;
            $display("FAIL ignore_start: %0d diffs md_end %0d, want 0 diffs md_end 9",
                     bit_diff(), md_end_cycle);
        end
        // Abort while the second bit is on the wire.
        md_start = 1'b1; num_in = 64'hF0; len_in = 8'd8; bit_ready = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tests_run++;
        if ({bit_valid, bit_out, bit_last, busy, md_end} !== 5'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got %b want 00000",
                     {bit_valid, bit_out, bit_last, busy, md_end});
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (md_end !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d cycles active after abort, want 0", bad);
        end
        build_exp(64'h2D, 8'd6);
        run_job(64'h2D, 8'd6, 100, 1'b0, 0);
        tests_run++;
        if (bit_diff() != 0 || md_end_cycle !== 7) begin
            tests_failed++;
            $display("FAIL abort_recover: %0d diffs md_end %0d, want 0 and 7",
                     bit_diff(), md_end_cycle);
        end
    endtask

    task automatic test_back_to_back();
        int k, bad;
        // Each job: L bit cycles, one DONE cycle, one IDLE cycle.
        md_start = 1'b1; num_in = 64'h3; len_in = 8'd2; bit_ready = 1'b1;
        tick();
        bad = 0;
        for (int c = 1; c <= 20; c++) begin
            k = ((c - 1) % 4) + 1;
            if (bit_valid !== (k <= 2) || md_end !== (k == 3) || busy !== (k != 4) ||
                (k <= 2 && bit_out !== 1'b1) || bit_last !== (k == 2)) begin
                bad++;
            end
            tick();
        end
        md_start = 1'b0;
        tick(); tick(); tick(); tick();
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL back_to_back: %0d cycles off the 4-cycle pattern, want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [63:0] num;
        logic [7:0]  len;
        int          leff, bad;
        bad = 0;
        for (int j = 0; j < 25; j++) begin
            num = {$urandom, $urandom};
            len = (j % 5 == 4) ? 8'($urandom) : 8'($urandom_range(0, 70));
            leff = (int'(len) > 64) ? 64 : int'(len);
            build_exp(num, len);
            run_job(num, len, 60, 1'b0, 0);
            if (bit_diff() != 0 || stab_bad != 0 || busy_bad != 0 ||
                last_cnt != ((leff > 0) ? 1 : 0) ||
                (leff > 0 && last_idx != leff - 1) ||
                md_end_cycle != ((leff > 0) ? last_xfer_cycle + 1 : 1) ||
                post_md_end !== 1'b0 || post_busy !== 1'b0) begin
                bad++;
                $display("FAIL random_job %0d: num %h len %0d diffs %0d md_end %0d last %0d/%0d",
                         j, num, len, bit_diff(), md_end_cycle, last_cnt, last_idx);
            end
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL random_summary: %0d bad jobs, want 0", bad);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_clamp();
        test_ignore_and_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
